// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// mult_div_unit : iterative multiply/divide for HI/LO (shift-add / restoring)
// Build option MD_UNSIGNED_EN adds the sgn input (MULTU/DIVU).   Rev 1.0
// ============================================================================
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
`ifdef MD_UNSIGNED_EN
  input  logic             sgn,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int            CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [WIDTH-1:0] r_acc, r_q, r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_busy, r_done, r_div0;
  logic             r_neg_q, r_neg_r, r_zero;

  logic             w_sgn;
`ifdef MD_UNSIGNED_EN
  assign w_sgn = sgn;
`else
  assign w_sgn = 1'b1;
`endif

  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  assign w_a_neg = w_sgn & a[WIDTH-1];
  assign w_b_neg = w_sgn & b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -a : a;
  assign w_b_mag = w_b_neg ? -b : b;

  // Multiply step: {r_acc, r_q} is the partial product shifting right.
  logic [WIDTH-1:0]   w_madd;
  logic [WIDTH:0]     w_msum;
  logic [2*WIDTH-1:0] w_mprod, w_mres;
  assign w_madd  = r_q[0] ? r_b : '0;
  assign w_msum  = {1'b0, r_acc} + {1'b0, w_madd};
  assign w_mprod = {w_msum, r_q[WIDTH-1:1]};
  assign w_mres  = r_neg_q ? -w_mprod : w_mprod;

  // Restoring divide step: r_acc is the remainder, r_q shifts dividend out / quotient in.
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;
  assign w_shift = {r_acc, r_q[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  assign w_sub   = w_shift[WIDTH-1:0] - r_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_div0  <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_div0 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_q     <= w_a_mag;
            r_b     <= w_b_mag;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_zero  <= op && (b == '0);
            r_busy  <= 1'b1;
            if (!op)
              r_state <= S_MUL;
            else if (b == '0)
              r_state <= S_FIX;   // spends one cycle so div0 timing matches the FIX path
            else
              r_state <= S_DIV;
          end
        end
        S_MUL: begin
          r_acc <= w_msum[WIDTH:1];
          r_q   <= {w_msum[0], r_q[WIDTH-1:1]};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == C_LAST) begin
            r_hi    <= w_mres[2*WIDTH-1:WIDTH];
            r_lo    <= w_mres[WIDTH-1:0];
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DIV: begin
          r_acc <= w_ge ? w_sub : w_shift[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == C_LAST)
            r_state <= S_FIX;
        end
        S_FIX: begin
          if (!r_zero) begin
            r_lo <= r_neg_q ? -r_q : r_q;
            r_hi <= r_neg_r ? -r_acc : r_acc;
          end
          r_done  <= 1'b1;
          r_div0  <= r_zero;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = r_busy;
  assign done = r_done;
  assign div0 = r_div0;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// tb_mult_div_unit : randomized and directed checks against an arithmetic model
// Rev 1.0
// ============================================================================
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start_i, op_i, sgn_i;
  logic [W-1:0] a_i, b_i, hi, lo;
  logic         busy, done, div0;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start_i), .op(op_i),
`ifdef MD_UNSIGNED_EN
    .sgn(sgn_i),
`endif
    .a(a_i), .b(b_i), .hi(hi), .lo(lo), .busy(busy), .done(done), .div0(div0)
  );

  always #5 clk = ~clk;

  // Architectural model: HI/LO registers updated by plain 64-bit arithmetic.
  task automatic model_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] eh, output logic [W-1:0] el,
                          output logic ed, output int elat);
    longint sx, sy, p, q, r;
    if (sgn_i) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'd0, x});
      sy = longint'({32'd0, y});
    end
    ed = 1'b0;
    if (!o) begin
      p = sx * sy;
      m_hi = p[63:32];
      m_lo = p[31:0];
      elat = W;
    end else if (y == '0) begin
      ed = 1'b1;
      elat = 1;
    end else begin
      q = sx / sy;
      r = sx % sy;
      m_lo = q[31:0];
      m_hi = r[31:0];
      elat = W + 1;
    end
    eh = m_hi;
    el = m_lo;
  endtask

  // Issues one operation from IDLE and waits (bounded) for done; scrambles inputs after the start edge.
  task automatic do_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat, output logic [W-1:0] gh, output logic [W-1:0] gl,
                       output logic gd);
    @(posedge clk); #1;
    op_i = o; a_i = x; b_i = y; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    op_i = 1'($urandom); a_i = $urandom; b_i = $urandom;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    gh = hi; gl = lo; gd = div0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start_i = 1'b0; op_i = 1'b0; a_i = '0; b_i = '0; sgn_i = 1'b1;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (div0 !== 1'b0) begin errors++; $display("FAIL reset_div0 got %b exp 0", div0); end
    checks++; if (hi !== '0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
    checks++; if (lo !== '0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_mult;
    int lat, elat; logic [W-1:0] gh, gl, eh, el; logic gd, ed;
    model_op(1'b0, 32'd7, 32'hFFFF_FFFD, eh, el, ed, elat);
    do_op(1'b0, 32'd7, 32'hFFFF_FFFD, lat, gh, gl, gd);
    checks++; if (lat !== 32) begin errors++; $display("FAIL mult_latency got %0d exp 32", lat); end
    checks++; if (gh !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_7x-3_hi got %h exp ffffffff", gh); end
    checks++; if (gl !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_7x-3_lo got %h exp ffffffeb", gl); end
    checks++; if (gd !== 1'b0) begin errors++; $display("FAIL mult_div0 got %b exp 0", gd); end
  endtask

  task automatic test_start_held;
    int n_done, e1, e2, elat; logic b33, b34, ed; logic [W-1:0] h1, l1, h2, l2, eh, el;
    n_done = 0; e1 = -1; e2 = -1; b33 = 1'bx; b34 = 1'bx;
    h1 = '0; l1 = '0; h2 = '0; l2 = '0;
    model_op(1'b0, 32'h8000_0000, 32'h8000_0000, eh, el, ed, elat);
    model_op(1'b0, 32'h8000_0000, 32'h8000_0000, eh, el, ed, elat);
    @(posedge clk); #1;
    op_i = 1'b0; a_i = 32'h8000_0000; b_i = 32'h8000_0000; start_i = 1'b1;
    @(posedge clk); #1;
    for (int e = 1; e <= 110; e++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        n_done++;
        if (n_done == 1) begin e1 = e; h1 = hi; l1 = lo; end
        else if (n_done == 2) begin e2 = e; h2 = hi; l2 = lo; end
      end
      if (e == 33) b33 = busy;
      if (e == 34) begin b34 = busy; start_i = 1'b0; end
    end
    checks++; if (e1 !== 32) begin errors++; $display("FAIL held_first_done_edge got %0d exp 32", e1); end
    checks++; if (h1 !== 32'h4000_0000) begin errors++; $display("FAIL mult_min_sq_hi got %h exp 40000000", h1); end
    checks++; if (l1 !== 32'h0) begin errors++; $display("FAIL mult_min_sq_lo got %h exp 0", l1); end
    checks++; if (b33 !== 1'b0) begin errors++; $display("FAIL held_idle_after_done busy got %b exp 0", b33); end
    checks++; if (b34 !== 1'b1) begin errors++; $display("FAIL held_restart busy got %b exp 1", b34); end
    checks++; if (n_done !== 2) begin errors++; $display("FAIL held_done_count got %0d exp 2", n_done); end
    checks++; if (e2 !== 66) begin errors++; $display("FAIL held_second_done_edge got %0d exp 66", e2); end
    checks++; if ({h2, l2} !== {eh, el}) begin errors++; $display("FAIL held_second_result got %h_%h exp %h_%h", h2, l2, eh, el); end
  endtask

  task automatic test_div;
    int lat, elat; logic [W-1:0] gh, gl, eh, el; logic gd, ed;
    model_op(1'b1, 32'hFFFF_FFF9, 32'd2, eh, el, ed, elat);
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, gh, gl, gd);
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency got %0d exp 33", lat); end
    checks++; if (gl !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_-7/2_lo got %h exp fffffffd", gl); end
    checks++; if (gh !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_-7/2_hi got %h exp ffffffff", gh); end
    model_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, eh, el, ed, elat);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, gh, gl, gd);
    checks++; if (gl !== 32'h8000_0000) begin errors++; $display("FAIL div_overflow_lo got %h exp 80000000", gl); end
    checks++; if (gh !== 32'h0) begin errors++; $display("FAIL div_overflow_hi got %h exp 0", gh); end
    checks++; if (gd !== 1'b0) begin errors++; $display("FAIL div_overflow_div0 got %b exp 0", gd); end
  endtask

  task automatic test_div0;
    int lat, elat; logic [W-1:0] gh, gl, eh, el, ph, pl; logic gd, ed;
    model_op(1'b0, 32'h0001_2345, 32'h0006_789A, eh, el, ed, elat);
    do_op(1'b0, 32'h0001_2345, 32'h0006_789A, lat, ph, pl, gd);
    model_op(1'b1, 32'd5, 32'd0, eh, el, ed, elat);
    do_op(1'b1, 32'd5, 32'd0, lat, gh, gl, gd);
    checks++; if (lat !== 1) begin errors++; $display("FAIL div0_latency got %0d exp 1", lat); end
    checks++; if (gd !== 1'b1) begin errors++; $display("FAIL div0_flag got %b exp 1", gd); end
    checks++; if ({gh, gl} !== {eh, el}) begin errors++; $display("FAIL div0_hold got %h_%h exp %h_%h", gh, gl, eh, el); end
    @(posedge clk); #1;
    checks++; if ({done, div0} !== 2'b00) begin errors++; $display("FAIL div0_clear got %b exp 00", {done, div0}); end
  endtask

  task automatic test_reset_mid;
    int lat, elat; logic [W-1:0] gh, gl, eh, el; logic gd, ed;
    model_op(1'b0, 32'd7, 32'hFFFF_FFFD, eh, el, ed, elat);
    do_op(1'b0, 32'd7, 32'hFFFF_FFFD, lat, gh, gl, gd);
    @(posedge clk); #1;
    op_i = 1'b0; a_i = 32'h1234_5678; b_i = 32'h0000_9ABC; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b exp 0", busy); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL midreset_hilo got %h_%h exp 0", hi, lo); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b exp 0", done); end
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    do_op(1'b0, 32'd3, 32'd4, lat, gh, gl, gd);
    checks++; if ({gh, gl} !== 64'd12) begin errors++; $display("FAIL after_reset_3x4 got %h_%h exp 0_c", gh, gl); end
    checks++; if (lat !== 32) begin errors++; $display("FAIL after_reset_latency got %0d exp 32", lat); end
  endtask

  task automatic test_random;
    int lat, elat, mode; logic o, ed, gd; logic [W-1:0] x, y, gh, gl, eh, el;
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 4);
      o = 1'($urandom);
      x = $urandom; y = $urandom;
      case (mode)
        1: begin o = 1'b1; y = '0; end
        2: begin o = 1'b1; x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        3: begin x = 32'($signed($urandom_range(0, 200)) - 100); y = 32'($signed($urandom_range(1, 41)) - 21); end
        4: y = 32'($urandom_range(1, 9));
        default: ;
      endcase
`ifdef MD_UNSIGNED_EN
      sgn_i = 1'($urandom);
`endif
      model_op(o, x, y, eh, el, ed, elat);
      do_op(o, x, y, lat, gh, gl, gd);
      checks++;
      if (lat !== elat || gh !== eh || gl !== el || gd !== ed) begin
        errors++;
        $display("FAIL random op=%b a=%h b=%h got lat=%0d %h_%h d0=%b exp lat=%0d %h_%h d0=%b",
                 o, x, y, lat, gh, gl, gd, elat, eh, el, ed);
      end
    end
    sgn_i = 1'b1;
  endtask

`ifdef MD_UNSIGNED_EN
  task automatic test_unsigned;
    int lat; logic [W-1:0] gh, gl; logic gd;
    sgn_i = 1'b0;
    do_op(1'b1, 32'hFFFF_FFFF, 32'd2, lat, gh, gl, gd);
    checks++; if ({gh, gl} !== {32'd1, 32'h7FFF_FFFF}) begin errors++; $display("FAIL divu got %h_%h exp 1_7fffffff", gh, gl); end
    do_op(1'b0, 32'hFFFF_FFFF, 32'd2, lat, gh, gl, gd);
    checks++; if ({gh, gl} !== {32'd1, 32'hFFFF_FFFE}) begin errors++; $display("FAIL multu got %h_%h exp 1_fffffffe", gh, gl); end
    sgn_i = 1'b1;
    do_op(1'b1, 32'hFFFF_FFFF, 32'd2, lat, gh, gl, gd);
    checks++; if ({gh, gl} !== {32'hFFFF_FFFF, 32'd0}) begin errors++; $display("FAIL div_signed got %h_%h exp ffffffff_0", gh, gl); end
    do_op(1'b0, 32'hFFFF_FFFF, 32'd2, lat, gh, gl, gd);
    checks++; if ({gh, gl} !== {32'hFFFF_FFFF, 32'hFFFF_FFFE}) begin errors++; $display("FAIL mult_signed got %h_%h exp ffffffff_fffffffe", gh, gl); end
    m_hi = gh; m_lo = gl;
  endtask
`endif

  initial begin
    test_reset();
    test_mult();
    test_start_held();
    test_div();
    test_div0();
    test_reset_mid();
    test_random();
`ifdef MD_UNSIGNED_EN
    test_unsigned();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
